// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM pipeline stage with a word-addressed data memory that
// behaves like a multi-cycle memory. Each load or store stalls upstream for
// WAIT_CYCLES cycles, then completes and drives the MEM/WB register.
// Ports:
//   clk, rst (async, active-low)
//   wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_Rm_in, dest_in : EX/MEM inputs
//   stall_out                          : combinational freeze request to upstream
//   wb_en_hazard_out, dest_hazard_out  : combinational hazard-unit taps
//   wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out : MEM/WB register
module mem_stage_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEST_W      = 4,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_Rm_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              stall_out,
  output logic              wb_en_hazard_out,
  output logic [DEST_W-1:0] dest_hazard_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DEST_W-1:0] dest_out
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam bit          HAS_WAIT = (WAIT_CYCLES > 0);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_req, w_stall, w_load, w_access, w_we;
  logic [DATA_W-1:0]  w_off;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  assign w_req = mem_r_en_in | mem_w_en_in;

  // Byte offset from the base, word-aligned and wrapped into the array
  assign w_off = alu_res_in - DATA_W'(BASE_ADDR);
  assign w_idx = IDX_W'(w_off >> 2);

  assign stall_out        = w_stall;
  assign wb_en_hazard_out = wb_en_in;
  assign dest_hazard_out  = dest_in;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_req && HAS_WAIT) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(CNT_INIT);
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        else             w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: stall, MEM/WB load-vs-bubble, and memory access strobe
  always_comb begin
    w_stall  = 1'b0;
    w_load   = 1'b0;
    w_access = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req && HAS_WAIT) begin
          w_stall = 1'b1;
        end else begin
          w_load   = 1'b1;
          w_access = w_req;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_stall = 1'b1;
        end else begin
          w_load   = 1'b1;
          w_access = 1'b1;
        end
      end
    endcase
  end

  assign w_we = w_access & mem_w_en_in;

  // MEM/WB pipeline register; a stall cycle loads a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
    end else if (w_load) begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      alu_res_out  <= alu_res_in;
      mem_data_out <= w_access ? r_mem[w_idx] : '0;
      dest_out     <= dest_in;
    end else begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
    end
  end

  // Data memory, not reset; read above sees the pre-write word
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= val_Rm_in;
  end

endmodule
